// File: rtl/system_led_driver_pkg.sv
// Shared constants for the LED driver: register map, CTRL bit layout,
// reset values and the PWM compare rule.
package system_led_driver_pkg;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_DUTY       = 2'd1;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam logic [1:0] CTRL_RST = 2'b01;
  localparam logic [7:0] DUTY_RST = 8'hFF;

  localparam int PRESC_W = 16;

  // Full scale forces the LEDs on; zero falls out of the compare as always-off.
  function automatic logic pwm_on(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

endpackage

// File: rtl/system_led_pwm_timebase.sv
// PWM timebase: clock prescaler feeding an 8-bit step counter, with a
// one-clock wrap pulse on the edge where the step counter rolls 255->0.
module system_led_pwm_timebase
  import system_led_driver_pkg::*;
#(
  parameter int unsigned PWM_DIV = 196
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pwm_cnt_o,
  output logic       tick_o,
  output logic       wrap_o
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic               tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // math lives in always_comb so the flops see a single consistent snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt_o = pwm_cnt_q;
  assign tick_o    = tick;
  assign wrap_o    = tick && (pwm_cnt_q == 8'hFF);

endmodule

// File: rtl/system_led_driver.sv
// LED driver behind the PIO: Avalon-MM register file, blink generator and
// the registered output stage combining pattern, blink, PWM and polarity.
module system_led_driver
  import system_led_driver_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_DIV  = 196,
  parameter int unsigned BLINK_W  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_pattern,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [1:0]          ctrl_q, ctrl_d;
  logic [7:0]          duty_shadow_q, duty_shadow_d;
  logic [7:0]          duty_act_q, duty_act_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [BLINK_W-1:0]  half_q, half_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  logic       wr, half_wr, on, pwm_tick, pwm_wrap;
  logic [7:0] pwm_cnt;
  logic [NUM_LEDS-1:0] gated, inv_vec;
  logic       unused_wdata;

  system_led_pwm_timebase #(.PWM_DIV(PWM_DIV)) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .pwm_cnt_o (pwm_cnt),
    .tick_o    (pwm_tick),
    .wrap_o    (pwm_wrap)
  );

  assign wr           = chipselect && !write_n;
  assign half_wr      = wr && (address == ADDR_BLINK_HALF);
  assign unused_wdata = ^{writedata, pwm_tick};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ctrl_d        = ctrl_q;
    duty_shadow_d = duty_shadow_q;
    mask_d        = mask_q;
    half_d        = half_q;
    if (wr) begin
      case (address)
        ADDR_CTRL:       ctrl_d        = writedata[1:0];
        ADDR_DUTY:       duty_shadow_d = writedata[7:0];
        ADDR_BLINK_MASK: mask_d        = writedata[NUM_LEDS-1:0];
        default:         half_d        = writedata[BLINK_W-1:0];
      endcase
    end
    // Active duty only changes at the period boundary to avoid a runt pulse.
    duty_act_d = pwm_wrap ? duty_shadow_q : duty_act_q;
  end

  // A half-period write restarts the blink on the lit phase and wins over
  // a terminal count landing on the same edge.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (half_wr || (half_q == '0)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == half_q) begin
      blink_cnt_d = '0;
      phase_d     = !phase_q;
    end
  end

  always_comb begin
    on      = pwm_on(pwm_cnt, duty_act_q);
    inv_vec = {NUM_LEDS{ctrl_q[CTRL_INV_BIT]}};
    gated   = led_pattern & ~(mask_q & ~{NUM_LEDS{phase_q}}) & {NUM_LEDS{on}};
    led_d   = ctrl_q[CTRL_EN_BIT] ? (gated ^ inv_vec) : inv_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q        <= CTRL_RST;
      duty_shadow_q <= DUTY_RST;
      duty_act_q    <= DUTY_RST;
      mask_q        <= '0;
      half_q        <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b1;
      led_q         <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_shadow_q <= duty_shadow_d;
      duty_act_q    <= duty_act_d;
      mask_q        <= mask_d;
      half_q        <= half_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      led_q         <= led_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:       readdata = 32'(ctrl_q);
      ADDR_DUTY:       readdata = 32'(duty_shadow_q);
      ADDR_BLINK_MASK: readdata = 32'(mask_q);
      default:         readdata = 32'(half_q);
    endcase
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_system_led_driver.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a time-based reference model of the LED driver.
module tb_system_led_driver;

  localparam int NUM_LEDS = 8;
  localparam int PWM_DIV  = 2;
  localparam int BLINK_W  = 24;
  localparam int PERIOD   = 256 * PWM_DIV;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          address;
  logic                chipselect;
  logic                write_n;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic [NUM_LEDS-1:0] led_pattern;
  logic [NUM_LEDS-1:0] led_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: state expressed as elapsed edge counts, not counters.
  int unsigned        e_cnt;   // clock edges since reset release
  int unsigned        w_cnt;   // e_cnt value right after the last BLINK_HALF write
  logic [1:0]         m_ctrl;
  logic [7:0]         m_shadow, m_active;
  logic [NUM_LEDS-1:0] m_mask;
  logic [BLINK_W-1:0] m_half;
  logic [NUM_LEDS-1:0] m_led;

  system_led_driver #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_DIV  (PWM_DIV),
    .BLINK_W  (BLINK_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .led_pattern (led_pattern),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_cnt    = 0;
    w_cnt    = 0;
    m_ctrl   = 2'b01;
    m_shadow = 8'hFF;
    m_active = 8'hFF;
    m_mask   = '0;
    m_half   = '0;
    m_led    = '0;
  endtask

  function automatic logic m_phase();
    int unsigned k;
    if (m_half == '0) return 1'b1;
    k = (e_cnt - w_cnt) / (int'(m_half) + 1);
    return (k % 2) == 0;
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_ctrl);
      2'd1:    return 32'(m_shadow);
      2'd2:    return 32'(m_mask);
      default: return 32'(m_half);
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs presented to it.
  task automatic model_edge();
    int unsigned         step;
    logic                on, ph;
    logic [7:0]          old_shadow;
    logic [NUM_LEDS-1:0] gated, inv;
    step  = (e_cnt / PWM_DIV) % 256;
    on    = (m_active == 8'hFF) || (step < int'(m_active));
    ph    = m_phase();
    inv   = {NUM_LEDS{m_ctrl[1]}};
    gated = led_pattern & ~(m_mask & ~{NUM_LEDS{ph}}) & {NUM_LEDS{on}};
    m_led = m_ctrl[0] ? (gated ^ inv) : inv;
    old_shadow = m_shadow;
    e_cnt++;
    if (e_cnt % PERIOD == 0) m_active = old_shadow;
    if (chipselect && !write_n) begin
      case (address)
        2'd0: m_ctrl   = writedata[1:0];
        2'd1: m_shadow = writedata[7:0];
        2'd2: m_mask   = writedata[NUM_LEDS-1:0];
        default: begin
          m_half = writedata[BLINK_W-1:0];
          w_cnt  = e_cnt;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("led", 32'(led_out), 32'(m_led));
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check("rd", readdata, m_reg(a));
    chipselect = 1'b0;
  endtask

  task automatic run_to_wrap();
    for (int i = 0; i < PERIOD; i++) begin
      if (e_cnt % PERIOD == 0) break;
      cycle();
    end
  endtask

  initial begin
    int on_cnt, off_cnt;
    logic [NUM_LEDS-1:0] exp_blink;

    reset       = 1'b0;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    led_pattern = '0;
    model_reset();
    #2 reset = 1'b1;
    #1 check("rst_led", 32'(led_out), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Pass-through with default registers.
    led_pattern = 8'hA5;
    cycle();
    check("pat_a5", 32'(led_out), 32'hA5);
    address = 2'd1; #1 check("rd_duty_rst", readdata, 32'hFF);
    address = 2'd0; #1 check("rd_ctrl_rst", readdata, 32'h1);

    // Duty change held off until the wrap, then 128 of 512 clocks lit.
    led_pattern = 8'hFF;
    reg_write(2'd1, 32'd64);
    check("duty_hold", 32'(led_out), 32'hFF);
    rd_check(2'd1);
    run_to_wrap();
    cycle();
    cycle();
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cycle();
      if (led_out == 8'hFF) on_cnt++;
      if (led_out == 8'h00) off_cnt++;
    end
    check("duty_on", 32'(on_cnt), 32'd128);
    check("duty_off", 32'(off_cnt), 32'd384);

    // Back to full brightness, then blink low nibble every 10 clocks.
    reg_write(2'd1, 32'hFF);
    run_to_wrap();
    cycle();
    reg_write(2'd2, 32'h0F);
    reg_write(2'd3, 32'd9);
    for (int i = 0; i < 40; i++) begin
      cycle();
      exp_blink = ((i / 10) % 2 == 0) ? 8'hFF : 8'hF0;
      check("blink", 32'(led_out), 32'(exp_blink));
    end

    // Polarity.
    reg_write(2'd3, 32'd0);
    reg_write(2'd2, 32'd0);
    led_pattern = 8'h0F;
    reg_write(2'd0, 32'h3);
    cycle();
    check("invert", 32'(led_out), 32'hF0);
    reg_write(2'd0, 32'h2);
    cycle();
    check("disable_inv", 32'(led_out), 32'hFF);

    // Half-period rewrite on the terminal count edge suppresses the toggle.
    reg_write(2'd0, 32'h1);
    led_pattern = 8'hFF;
    reg_write(2'd2, 32'h0F);
    reg_write(2'd3, 32'd4);
    repeat (4) cycle();
    reg_write(2'd3, 32'd4);
    repeat (5) begin
      cycle();
      check("no_toggle", 32'(led_out), 32'hFF);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      led_pattern = NUM_LEDS'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0:    d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h1;
          2'd1:    d = ($urandom_range(0, 2) == 0) ? 32'h0 :
                       ($urandom_range(0, 1) == 0) ? 32'hFF : 32'($urandom_range(0, 255));
          2'd2:    d = $urandom;
          default: d = 32'($urandom_range(0, 6));
        endcase
        reg_write(a, d);
      end else begin
        cycle();
      end
      if ($urandom_range(0, 15) == 0) rd_check(2'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-blink with invert set.
    reg_write(2'd0, 32'h3);
    reg_write(2'd2, 32'hF0);
    reg_write(2'd3, 32'd3);
    repeat (6) cycle();
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(led_out), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    address = 2'd0; #1 check("rst_ctrl", readdata, 32'h1);
    address = 2'd1; #1 check("rst_duty", readdata, 32'hFF);
    address = 2'd2; #1 check("rst_mask", readdata, 32'h0);
    address = 2'd3; #1 check("rst_half", readdata, 32'h0);
    led_pattern = 8'h3C;
    cycle();
    check("rst_mirror", 32'(led_out), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
